mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter (instruction fetch / data) sharing one memory bus.
// Ports: clk, reset (async, high); fetch port if_req/if_addr -> if_rdata/if_ack;
// data port d_req/d_we/d_addr/d_wdata/d_strb -> d_rdata/d_ack/d_err;
// memory side mem_req/mem_we/mem_addr/mem_wdata/mem_wmask <- mem_rdata/mem_ready;
// busy is high whenever the arbiter is not idle.
module mem_bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_strb,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] l_addr, l_wdata;
    logic [2:0]  l_strb;
    logic        l_we, l_data;
    logic        pri_data;
    logic        err_q;
    logic [7:0]  tmo_cnt;

    logic        grant_d, grant_if, d_bad, acc, tmo_hit;
    logic [31:0] lane_wdata, ld_val;
    logic [3:0]  lane_mask;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Arbitration and request qualification
    always_comb begin
        grant_d  = d_req && (pri_data || !if_req);
        grant_if = if_req && !grant_d;
        d_bad    = 1'b1;
        unique case (d_strb)
            3'b000, 3'b100: d_bad = 1'b0;
            3'b001, 3'b101: d_bad = d_addr[0];
            3'b010:         d_bad = |d_addr[1:0];
            default:        d_bad = 1'b1;
        endcase
        acc     = (state == IF_ACC) || (state == D_ACC);
        // Last permitted wait cycle without mem_ready ends the access
        tmo_hit = acc && !mem_ready && (tmo_cnt == TMO_LAST);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant_d)       state_nxt = d_bad ? DONE : D_ACC;
                else if (grant_if) state_nxt = IF_ACC;
            end
            IF_ACC, D_ACC: begin
                if (mem_ready || tmo_hit) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
        endcase
    end

    // Store lane steering and load extraction from the latched request
    always_comb begin
        lane_wdata = l_wdata;
        lane_mask  = 4'b1111;
        unique case (l_strb[1:0])
            2'b00: begin
                lane_wdata = {4{l_wdata[7:0]}};
                lane_mask  = 4'b0001 << l_addr[1:0];
            end
            2'b01: begin
                lane_wdata = {2{l_wdata[15:0]}};
                lane_mask  = 4'b0011 << l_addr[1:0];
            end
            default: begin
                lane_wdata = l_wdata;
                lane_mask  = 4'b1111;
            end
        endcase
        ld_byte = mem_rdata[{l_addr[1:0], 3'b000} +: 8];
        ld_half = l_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (l_strb)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_val = {24'h0, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_val = {16'h0, ld_half};
            default: ld_val = mem_rdata;
        endcase
    end

    // Output logic
    always_comb begin
        mem_req   = acc;
        mem_we    = (state == D_ACC) && l_we;
        mem_addr  = {l_addr[31:2], 2'b00};
        mem_wdata = lane_wdata;
        mem_wmask = mem_we ? lane_mask : 4'b0000;
        if_ack    = (state == DONE) && !l_data;
        d_ack     = (state == DONE) && l_data;
        d_err     = d_ack && err_q;
        busy      = (state != IDLE);
    end

    // Request latches, priority pointer, timeout counter, read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l_addr   <= '0;
            l_wdata  <= '0;
            l_strb   <= '0;
            l_we     <= 1'b0;
            l_data   <= 1'b0;
            pri_data <= 1'b1;
            err_q    <= 1'b0;
            tmo_cnt  <= '0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            if (state == IDLE && grant_d) begin
                l_addr   <= d_addr;
                l_wdata  <= d_wdata;
                l_strb   <= d_strb;
                l_we     <= d_we;
                l_data   <= 1'b1;
                pri_data <= 1'b0;
                err_q    <= d_bad;
                tmo_cnt  <= '0;
            end else if (state == IDLE && grant_if) begin
                l_addr   <= if_addr;
                l_strb   <= 3'b010;
                l_we     <= 1'b0;
                l_data   <= 1'b0;
                pri_data <= 1'b1;
                err_q    <= 1'b0;
                tmo_cnt  <= '0;
            end
            if (acc) begin
                if (mem_ready) begin
                    if (!l_data)   if_rdata <= mem_rdata;
                    else if (!l_we) d_rdata <= ld_val;
                end else if (tmo_hit) begin
                    err_q <= 1'b1;
                    if (!l_data) if_rdata <= NOP;
                end else begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus random
// traffic checked every cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [2:0]  d_strb = '0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_strb(d_strb), .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---- specification arithmetic ----
    function automatic int size_of(input logic [2:0] s);
        return 1 << s[1:0];
    endfunction

    function automatic logic bad_of(input logic [2:0] s, input logic [31:0] a);
        if (!(s inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        return (a % 32'(size_of(s))) != 0;
    endfunction

    function automatic logic [3:0] mask_of(input logic [2:0] s, input logic [31:0] a);
        int m;
        m = ((1 << size_of(s)) - 1) << (a % 4);
        return 4'(m);
    endfunction

    function automatic logic [31:0] wdata_of(input logic [2:0] s, input logic [31:0] w);
        if (size_of(s) == 1) return (w & 32'hFF) * 32'h0101_0101;
        if (size_of(s) == 2) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] load_of(input logic [2:0] s, input logic [31:0] a,
                                            input logic [31:0] r);
        int bits;
        logic [31:0] lim, v;
        if (size_of(s) == 4) return r;
        bits = 8 * size_of(s);
        lim = (32'h1 << bits) - 1;
        v = (r >> (8 * (a % 4))) & lim;
        if (!s[2] && ((v >> (bits - 1)) & 1) == 1) v = v | ~lim;
        return v;
    endfunction

    // ---- reference model: one outstanding transaction, phase 0 idle,
    // 1 waiting on memory, 2 acknowledging ----
    int          m_ph;
    int          m_waited;
    logic        m_data, m_we, m_err, m_pri_data;
    logic [2:0]  m_strb;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ph <= 0;
            m_waited <= 0;
            m_pri_data <= 1'b1;
            m_data <= 1'b0;
            m_we <= 1'b0;
            m_err <= 1'b0;
            m_if_rdata <= '0;
            m_d_rdata <= '0;
        end else if (m_ph == 0) begin
            if (d_req && (m_pri_data || !if_req)) begin
                m_data <= 1'b1;
                m_we <= d_we;
                m_addr <= d_addr;
                m_wdata <= d_wdata;
                m_strb <= d_strb;
                m_pri_data <= 1'b0;
                m_waited <= 0;
                m_err <= bad_of(d_strb, d_addr);
                m_ph <= bad_of(d_strb, d_addr) ? 2 : 1;
            end else if (if_req) begin
                m_data <= 1'b0;
                m_we <= 1'b0;
                m_addr <= if_addr;
                m_strb <= 3'd2;
                m_pri_data <= 1'b1;
                m_waited <= 0;
                m_err <= 1'b0;
                m_ph <= 1;
            end
        end else if (m_ph == 1) begin
            if (mem_ready) begin
                m_ph <= 2;
                if (!m_data) m_if_rdata <= mem_rdata;
                else if (!m_we) m_d_rdata <= load_of(m_strb, m_addr, mem_rdata);
            end else if (m_waited + 1 >= TMO) begin
                m_ph <= 2;
                m_err <= 1'b1;
                if (!m_data) m_if_rdata <= 32'h0000_0013;
            end else begin
                m_waited <= m_waited + 1;
            end
        end else begin
            m_ph <= 0;
        end
    end

    logic e_req, e_we, e_ifa, e_da;
    assign e_req = (m_ph == 1);
    assign e_we  = e_req && m_data && m_we;
    assign e_ifa = (m_ph == 2) && !m_data;
    assign e_da  = (m_ph == 2) && m_data;

    // ---- per-cycle comparison ----
    always @(negedge clk) begin
        chk("mem_req", mem_req, e_req);
        chk("mem_we", mem_we, e_we);
        chk("mem_wmask", mem_wmask, e_we ? mask_of(m_strb, m_addr) : 4'h0);
        if (e_req) chk("mem_addr", mem_addr, m_addr & ~32'h3);
        if (e_we) chk("mem_wdata", mem_wdata, wdata_of(m_strb, m_wdata));
        chk("if_ack", if_ack, e_ifa);
        chk("d_ack", d_ack, e_da);
        chk("d_err", d_err, e_da && m_err);
        chk("busy", busy, m_ph != 0);
        chk("if_rdata", if_rdata, m_if_rdata);
        chk("d_rdata", d_rdata, m_d_rdata);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic d_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] s, input logic [31:0] rd,
                        output logic [3:0] wm, output logic [31:0] wdo,
                        output logic wev, output logic ack, output logic err);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_strb = s;
        mem_ready = 1'b0;
        cyc();
        wm = mem_wmask; wdo = mem_wdata; wev = mem_we;
        mem_ready = 1'b1; mem_rdata = rd;
        cyc();
        ack = d_ack; err = d_err;
        d_req = 1'b0; mem_ready = 1'b0;
        cyc();
    endtask

    logic [3:0]  t_wm;
    logic [31:0] t_wd;
    logic        t_we, t_ack, t_err;
    logic [2:0]  legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0]  illegal [3] = '{3'd3, 3'd6, 3'd7};

    initial begin
        cyc();
        cyc();
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        reset = 1'b0;

        // simultaneous requests right after reset: data first, then fetch
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_strb = 3'd2;
        mem_ready = 1'b1; mem_rdata = 32'h1122_3344;
        cyc();
        chk("arb_first_data", mem_addr, 32'h80);
        cyc();
        chk("arb_data_ack", d_ack, 1'b1);
        chk("arb_data_rdata", d_rdata, 32'h1122_3344);
        d_req = 1'b0;
        cyc();
        cyc();
        chk("arb_second_fetch", mem_addr, 32'h40);
        cyc();
        chk("arb_fetch_ack", if_ack, 1'b1);
        if_req = 1'b0; mem_ready = 1'b0;
        cyc();

        // basic fetch
        if_req = 1'b1; if_addr = 32'h100;
        cyc();
        chk("fetch_addr", mem_addr, 32'h100);
        mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
        cyc();
        chk("fetch_ack", if_ack, 1'b1);
        chk("fetch_rdata", if_rdata, 32'h0050_0093);
        if_req = 1'b0; mem_ready = 1'b0;
        cyc();

        // SB to byte lane 3
        d_op(1'b1, 32'h203, 32'h0000_00AB, 3'd0, 32'h0, t_wm, t_wd, t_we, t_ack, t_err);
        chk("sb_mask", t_wm, 4'b1000);
        chk("sb_wdata", t_wd, 32'hABAB_ABAB);
        chk("sb_we", t_we, 1'b1);
        chk("sb_ack", t_ack, 1'b1);
        chk("sb_err", t_err, 1'b0);

        // LH / LHU on upper halfword
        d_op(1'b0, 32'h202, 32'h0, 3'd1, 32'h8001_1234, t_wm, t_wd, t_we, t_ack, t_err);
        chk("lh_rdata", d_rdata, 32'hFFFF_8001);
        chk("lh_model", m_d_rdata, 32'hFFFF_8001);
        d_op(1'b0, 32'h202, 32'h0, 3'd5, 32'h8001_1234, t_wm, t_wd, t_we, t_ack, t_err);
        chk("lhu_rdata", d_rdata, 32'h0000_8001);
        chk("lhu_model", m_d_rdata, 32'h0000_8001);

        // misaligned LW: no memory access, error one cycle after grant
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h201; d_strb = 3'd2;
        cyc();
        chk("mis_ack", d_ack, 1'b1);
        chk("mis_err", d_err, 1'b1);
        chk("mis_mem_req", mem_req, 1'b0);
        d_req = 1'b0;
        cyc();
        chk("mis_rdata_kept", d_rdata, 32'h0000_8001);

        // data timeout after TMO wait cycles
        d_req = 1'b1; d_addr = 32'h300; d_strb = 3'd2; mem_ready = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            cyc();
            chk("tmo_d_acc", mem_req, 1'b1);
        end
        cyc();
        chk("tmo_d_ack", d_ack, 1'b1);
        chk("tmo_d_err", d_err, 1'b1);
        d_req = 1'b0;
        cyc();

        // fetch timeout returns a NOP
        if_req = 1'b1; if_addr = 32'h600;
        for (int i = 0; i < TMO; i++) begin
            cyc();
            chk("tmo_if_acc", mem_req, 1'b1);
        end
        cyc();
        chk("tmo_if_ack", if_ack, 1'b1);
        chk("tmo_if_nop", if_rdata, 32'h0000_0013);
        if_req = 1'b0;
        cyc();

        // reset in the middle of a store, then a clean fetch
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h400; d_wdata = 32'h1234_5678;
        d_strb = 3'd2;
        cyc();
        chk("rst_store_we", mem_we, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("rst_drop_req", mem_req, 1'b0);
        chk("rst_drop_we", mem_we, 1'b0);
        cyc();
        chk("rst_no_ack", d_ack, 1'b0);
        reset = 1'b0; d_req = 1'b0;
        if_req = 1'b1; if_addr = 32'h500; mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        cyc();
        chk("post_rst_addr", mem_addr, 32'h500);
        cyc();
        chk("post_rst_ack", if_ack, 1'b1);
        chk("post_rst_rdata", if_rdata, 32'hDEAD_BEEF);
        if_req = 1'b0; mem_ready = 1'b0;
        cyc();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if (if_ack) if_req = 1'b0;
            else if (!if_req && ($urandom % 3) == 0) begin
                if_req = 1'b1;
                if_addr = $urandom & ~32'h3;
            end
            if (d_ack) d_req = 1'b0;
            else if (!d_req && ($urandom % 3) == 0) begin
                d_req = 1'b1;
                d_we = 1'($urandom % 2);
                d_addr = $urandom;
                if (($urandom % 4) != 0) d_addr[1:0] = 2'b00;
                d_wdata = $urandom;
                if (($urandom % 10) == 0) d_strb = illegal[$urandom % 3];
                else d_strb = legal[$urandom % 5];
            end
            mem_ready = ($urandom % 3) == 0;
            mem_rdata = $urandom;
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
